// File: rtl/frame_level_pkg.sv
// Shared types and constants for the frame level meter.
// Full-scale constants are given for the default sample width.
package frame_level_pkg;

  localparam int unsigned DEF_SAMPLE_W   = 24;
  localparam int unsigned DEF_DATA_W     = 32;
  localparam int unsigned DEF_FRAME_LOG2 = 8;

  localparam logic signed [DEF_SAMPLE_W-1:0] POS_FS = {1'b0, {(DEF_SAMPLE_W-1){1'b1}}};
  localparam logic signed [DEF_SAMPLE_W-1:0] NEG_FS = {1'b1, {(DEF_SAMPLE_W-1){1'b0}}};

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StDrain,
    StDone
  } state_e;

  // The sum of 2^frame_log2 squared magnitudes fits without overflow.
  function automatic int unsigned acc_width(input int unsigned sample_w,
                                            input int unsigned frame_log2);
    return 2 * sample_w - 2 + frame_log2;
  endfunction

endpackage

// File: rtl/sample_abs_sq.sv
// Registered saturating magnitude and clip detect; the square of the
// registered magnitude is presented for the consumer's next-edge accumulate.
module sample_abs_sq
  import frame_level_pkg::*;
#(
  parameter int unsigned SAMPLE_W = DEF_SAMPLE_W
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  input  logic [SAMPLE_W-1:0]   sample_i,
  output logic                  valid_o,
  output logic [SAMPLE_W-2:0]   abs_o,
  output logic                  clip_o,
  output logic [2*SAMPLE_W-3:0] sq_o
);

  localparam int unsigned SQ_W = 2 * SAMPLE_W - 2;
  localparam logic [SAMPLE_W-1:0] LP_POS = {1'b0, {(SAMPLE_W-1){1'b1}}};
  localparam logic [SAMPLE_W-1:0] LP_NEG = {1'b1, {(SAMPLE_W-1){1'b0}}};

  logic [SAMPLE_W-1:0] w_neg;
  logic [SAMPLE_W-2:0] w_abs;
  logic                w_clip;
  logic [SQ_W-1:0]     w_abs_ext;

  logic                r_valid;
  logic [SAMPLE_W-2:0] r_abs;
  logic                r_clip;

  assign w_neg = -sample_i;

  always_comb begin
    w_abs = sample_i[SAMPLE_W-1] ? w_neg[SAMPLE_W-2:0] : sample_i[SAMPLE_W-2:0];
    // The most negative code has no positive twin; clamp it.
    if (sample_i == LP_NEG) begin
      w_abs = '1;
    end
    w_clip = (sample_i == LP_POS) || (sample_i == LP_NEG);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid <= 1'b0;
      r_abs   <= '0;
      r_clip  <= 1'b0;
    end else begin
      r_valid <= valid_i;
      if (valid_i) begin
        r_abs  <= w_abs;
        r_clip <= w_clip;
      end
    end
  end

  assign w_abs_ext = {{(SAMPLE_W-1){1'b0}}, r_abs};

  assign valid_o = r_valid;
  assign abs_o   = r_abs;
  assign clip_o  = r_clip;
  assign sq_o    = w_abs_ext * w_abs_ext;

endmodule

// File: rtl/frame_level_meter.sv
// Drains one frame from the RAM read port and publishes its peak magnitude,
// mean square and clip flag with a one-cycle valid strobe.
module frame_level_meter
  import frame_level_pkg::*;
#(
  parameter int unsigned SAMPLE_W   = DEF_SAMPLE_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned FRAME_LOG2 = DEF_FRAME_LOG2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_W-1:0]     ram_read_data_i,
  input  logic                  ram_read_valid_i,
  output logic                  ram_read_ready_o,
  input  logic                  ram_buffer_ready_i,
  output logic                  level_valid_o,
  output logic [SAMPLE_W-2:0]   peak_o,
  output logic [2*SAMPLE_W-3:0] mean_sq_o,
  output logic                  clip_o,
  output logic                  busy_o,
  output logic [15:0]           frame_count_o
);

  localparam int unsigned ACC_W = acc_width(SAMPLE_W, FRAME_LOG2);
  localparam int unsigned SQ_W  = 2 * SAMPLE_W - 2;

  state_e                r_state;
  logic [FRAME_LOG2-1:0] r_beat;
  logic [ACC_W-1:0]      r_acc;
  logic [SAMPLE_W-2:0]   r_peak;
  logic                  r_clip_acc;
  logic                  r_level_valid;
  logic [SAMPLE_W-2:0]   r_peak_out;
  logic [SQ_W-1:0]       r_mean_sq;
  logic                  r_clip_out;
  logic [15:0]           r_frame_count;

  logic                  w_accept;
  logic                  w_s2_valid;
  logic [SAMPLE_W-2:0]   w_abs;
  logic                  w_clip;
  logic [SQ_W-1:0]       w_sq;
  logic                  w_unused_upper;

  assign w_accept       = (r_state == StRead) && ram_read_valid_i;
  assign w_unused_upper = ^ram_read_data_i[DATA_W-1:SAMPLE_W];

  sample_abs_sq #(
    .SAMPLE_W (SAMPLE_W)
  ) u_abs_sq (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .valid_i  (w_accept),
    .sample_i (ram_read_data_i[SAMPLE_W-1:0]),
    .valid_o  (w_s2_valid),
    .abs_o    (w_abs),
    .clip_o   (w_clip),
    .sq_o     (w_sq)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= StIdle;
      r_beat        <= '0;
      r_acc         <= '0;
      r_peak        <= '0;
      r_clip_acc    <= 1'b0;
      r_level_valid <= 1'b0;
      r_peak_out    <= '0;
      r_mean_sq     <= '0;
      r_clip_out    <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_level_valid <= 1'b0;
      if (w_s2_valid) begin
        if (w_abs > r_peak) begin
          r_peak <= w_abs;
        end
        r_acc      <= r_acc + ACC_W'(w_sq);
        r_clip_acc <= r_clip_acc | w_clip;
      end
      unique case (r_state)
        StIdle: begin
          if (ram_buffer_ready_i) begin
            r_state    <= StRead;
            r_beat     <= '0;
            r_acc      <= '0;
            r_peak     <= '0;
            r_clip_acc <= 1'b0;
          end
        end
        StRead: begin
          if (w_accept) begin
            r_beat <= r_beat + 1'b1;
            if (r_beat == '1) begin
              r_state <= StDrain;
            end
          end
        end
        // Final beat lands in the accumulator on this edge.
        StDrain: r_state <= StDone;
        StDone: begin
          r_peak_out    <= r_peak;
          r_mean_sq     <= r_acc[ACC_W-1:FRAME_LOG2];
          r_clip_out    <= r_clip_acc;
          r_level_valid <= 1'b1;
          r_frame_count <= r_frame_count + 16'd1;
          r_state       <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign ram_read_ready_o = (r_state == StRead);
  assign busy_o           = (r_state != StIdle);
  assign level_valid_o    = r_level_valid;
  assign peak_o           = r_peak_out;
  assign mean_sq_o        = r_mean_sq;
  assign clip_o           = r_clip_out;
  assign frame_count_o    = r_frame_count;

endmodule

// File: tb/tb_frame_level_meter.sv
// Randomized bench for frame_level_meter with a per-frame arithmetic model.
module tb_frame_level_meter;
  import frame_level_pkg::*;

  localparam int FLEN = 256;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] ram_read_data_i;
  logic        ram_read_valid_i;
  logic        ram_read_ready_o;
  logic        ram_buffer_ready_i;
  logic        level_valid_o;
  logic [22:0] peak_o;
  logic [45:0] mean_sq_o;
  logic        clip_o;
  logic        busy_o;
  logic [15:0] frame_count_o;

  int          n_checks = 0;
  int          n_fail = 0;
  int          strobes = 0;

  logic [31:0] words[$];
  int          exp_peak;
  logic [45:0] exp_mean;
  logic        exp_clip;
  logic [15:0] exp_fc;

  frame_level_meter dut (
    .clk_i              (clk),
    .rst_i              (rst_i),
    .ram_read_data_i    (ram_read_data_i),
    .ram_read_valid_i   (ram_read_valid_i),
    .ram_read_ready_o   (ram_read_ready_o),
    .ram_buffer_ready_i (ram_buffer_ready_i),
    .level_valid_o      (level_valid_o),
    .peak_o             (peak_o),
    .mean_sq_o          (mean_sq_o),
    .clip_o             (clip_o),
    .busy_o             (busy_o),
    .frame_count_o      (frame_count_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (level_valid_o) strobes <= strobes + 1;

  // Frame statistics straight from the definitions: saturated |s|, max, sum of squares / N.
  task automatic model();
    longint sum = 0;
    int     pk = 0;
    bit     cl = 1'b0;
    foreach (words[i]) begin
      logic [31:0] w;
      int s, a;
      w = words[i];
      s = int'($signed(w[23:0]));
      if (s == int'(POS_FS) || s == int'(NEG_FS)) cl = 1'b1;
      a = (s < 0) ? -s : s;
      if (a > int'(POS_FS)) a = int'(POS_FS);
      if (a > pk) pk = a;
      sum += longint'(a) * longint'(a);
    end
    exp_peak = pk;
    exp_mean = 46'(sum / FLEN);
    exp_clip = cl;
  endtask

  // mode 0: valid always high, 1: toggled every cycle, 2: random.
  task automatic run_frame(input int mode, input bit drop_br, input bit chk_ready);
    int idx = 0;
    int guard = 0;
    int ready_cyc = 0;
    int lat = 0;
    bit tog = 1'b0;
    bit v;
    model();
    ram_buffer_ready_i = 1'b1;
    while (idx < FLEN && guard < 4000) begin
      @(negedge clk);
      guard++;
      if (ram_read_ready_o) ready_cyc++;
      case (mode)
        0: v = 1'b1;
        1: begin v = tog; tog = ~tog; end
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      ram_read_valid_i = v;
      ram_read_data_i  = v ? words[idx] : $urandom;
      if (drop_br && idx == 50) ram_buffer_ready_i = 1'b0;
      if (ram_read_ready_o && v) idx++;
    end
    n_checks++;
    if (idx !== FLEN) begin
      n_fail++;
      $display("FAIL beats_accepted: got %0d required %0d", idx, FLEN);
      return;
    end
    @(negedge clk);
    ram_read_valid_i = 1'b0;
    ram_read_data_i  = $urandom;
    while (!level_valid_o && lat < 10) begin
      if (ram_read_ready_o) ready_cyc++;
      lat++;
      @(negedge clk);
    end
    exp_fc = exp_fc + 16'd1;
    n_checks++;
    if (lat !== 2) begin
      n_fail++;
      $display("FAIL strobe_latency: got %0d edges required 2", lat);
    end
    n_checks++;
    if (int'(peak_o) !== exp_peak) begin
      n_fail++;
      $display("FAIL peak: got %0d required %0d", peak_o, exp_peak);
    end
    n_checks++;
    if (mean_sq_o !== exp_mean) begin
      n_fail++;
      $display("FAIL mean_sq: got %0d required %0d", mean_sq_o, exp_mean);
    end
    n_checks++;
    if (clip_o !== exp_clip) begin
      n_fail++;
      $display("FAIL clip: got %0b required %0b", clip_o, exp_clip);
    end
    n_checks++;
    if (frame_count_o !== exp_fc) begin
      n_fail++;
      $display("FAIL frame_count: got %0d required %0d", frame_count_o, exp_fc);
    end
    n_checks++;
    if (busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_at_strobe: busy got %0b required 0", busy_o);
    end
    if (chk_ready) begin
      n_checks++;
      if (ready_cyc !== FLEN) begin
        n_fail++;
        $display("FAIL ready_cycles: got %0d required %0d", ready_cyc, FLEN);
      end
    end
  endtask

  task automatic pulse_reset();
    ram_buffer_ready_i = 1'b0;
    ram_read_valid_i   = 1'b0;
    @(negedge clk);
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    rst_i  = 1'b0;
    exp_fc = 16'd0;
  endtask

  task automatic test_reset();
    rst_i              = 1'b1;
    ram_buffer_ready_i = 1'b1;
    ram_read_valid_i   = 1'b1;
    ram_read_data_i    = 32'h007F_FFFF;
    exp_fc             = 16'd0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({level_valid_o, peak_o, mean_sq_o, clip_o, busy_o, frame_count_o, ram_read_ready_o}
        !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: lv=%0b peak=%0d mean=%0d clip=%0b busy=%0b fc=%0d rdy=%0b",
               level_valid_o, peak_o, mean_sq_o, clip_o, busy_o, frame_count_o,
               ram_read_ready_o);
    end
    ram_buffer_ready_i = 1'b0;
    ram_read_valid_i   = 1'b0;
    rst_i              = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy_o, ram_read_ready_o, level_valid_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy=%0b rdy=%0b lv=%0b required 0",
               busy_o, ram_read_ready_o, level_valid_o);
    end
  endtask

  task automatic test_constant();
    words.delete();
    for (int i = 0; i < FLEN; i++) words.push_back(32'd1000);
    run_frame(0, 1'b0, 1'b1);
    @(negedge clk);
    n_checks++;
    if (level_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL strobe_width: level_valid got %0b one cycle after strobe required 0",
               level_valid_o);
    end
  endtask

  task automatic test_stall();
    words.delete();
    for (int i = 0; i < FLEN; i++) words.push_back((i % 2 == 0) ? 32'd2000 : 32'hFFFF_F830);
    run_frame(1, 1'b0, 1'b0);
  endtask

  task automatic test_neg_fs();
    int pos;
    pos = $urandom_range(0, FLEN - 1);
    words.delete();
    for (int i = 0; i < FLEN; i++) words.push_back((i == pos) ? 32'h0080_0000 : 32'h0);
    run_frame(2, 1'b0, 1'b0);
  endtask

  task automatic test_upper_bits();
    logic [22:0] held_peak;
    logic [45:0] held_mean;
    words.delete();
    for (int i = 0; i < FLEN; i++) words.push_back(32'hFF00_0000);
    run_frame(0, 1'b0, 1'b0);
    ram_buffer_ready_i = 1'b0;
    held_peak = peak_o;
    held_mean = mean_sq_o;
    repeat (5) @(negedge clk);
    n_checks++;
    if ({peak_o, mean_sq_o} !== {held_peak, held_mean}) begin
      n_fail++;
      $display("FAIL result_hold: peak=%0d mean=%0d required %0d %0d",
               peak_o, mean_sq_o, held_peak, held_mean);
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 2; f++) begin
      words.delete();
      for (int i = 0; i < FLEN; i++) begin
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 15))
          0: w[23:0] = 24'h7F_FFFF;
          1: w[23:0] = 24'h80_0000;
          2: w[23:0] = 24'h0;
          default: ;
        endcase
        words.push_back(w);
      end
      run_frame(2, 1'b1, 1'b0);
    end
  endtask

  task automatic test_reset_mid_frame();
    int idx = 0;
    int guard = 0;
    int s0;
    ram_buffer_ready_i = 1'b1;
    while (idx < 100 && guard < 1000) begin
      @(negedge clk);
      guard++;
      ram_read_valid_i = 1'b1;
      ram_read_data_i  = 32'h0080_0000;
      if (ram_read_ready_o) idx++;
    end
    pulse_reset();
    #1;
    s0 = strobes;
    n_checks++;
    if ({frame_count_o, busy_o, level_valid_o} !== 18'h0) begin
      n_fail++;
      $display("FAIL abort_state: fc=%0d busy=%0b lv=%0b required 0",
               frame_count_o, busy_o, level_valid_o);
    end
    words.delete();
    for (int i = 0; i < FLEN; i++) words.push_back({8'h0, 8'h0, 8'($urandom)});
    run_frame(0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (strobes !== s0 + 1) begin
      n_fail++;
      $display("FAIL abort_strobes: got %0d strobes after reset required 1", strobes - s0);
    end
  endtask

  task automatic test_back_to_back();
    pulse_reset();
    for (int f = 0; f < 3; f++) begin
      words.delete();
      for (int i = 0; i < FLEN; i++) words.push_back($urandom);
      run_frame(0, 1'b0, 1'b1);
    end
    n_checks++;
    if (frame_count_o !== 16'd3) begin
      n_fail++;
      $display("FAIL back_to_back_count: got %0d required 3", frame_count_o);
    end
  endtask

  initial begin
    test_reset();
    test_constant();
    test_stall();
    test_neg_fs();
    test_upper_bits();
    test_random();
    test_reset_mid_frame();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
